// File: rtl/puf_eval_ctrl.sv
// Evaluation sequencer for the parallel ring-oscillator PUF: latches a challenge, runs the
// clear/settle/count/sample window and holds the response with done until ack. Optional macro: PUF_MAJORITY_EN.
module puf_eval_ctrl #(
    parameter int N_PAIRS       = 8,
    parameter int CH_W          = 8,
    parameter int EN_W          = 32,
    parameter int SETTLE_CYCLES = 16,
    parameter int WINDOW_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CH_W-1:0]    challenge_in,
    input  logic               ack,
    input  logic [N_PAIRS-1:0] cmp_bits,
    output logic [CH_W-1:0]    challenge_out,
    output logic [EN_W-1:0]    ro_en,
    output logic               cnt_clr,
    output logic               cnt_en,
    output logic [N_PAIRS-1:0] response,
    output logic               done,
    output logic               busy
);
    localparam int MAX_CYC = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] WINDOW_LD = CNT_W'(WINDOW_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_SETTLE = 3'd2,
        S_COUNT  = 3'd3,
        S_SAMPLE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               start_q_r;
    logic               start_edge_s;
    logic               accept_s;
    logic [CNT_W-1:0]   cyc_cnt_r;
    logic               cyc_last_s;
    logic               last_pass_s;
    logic               run_nxt_s;
    logic [N_PAIRS-1:0] resp_nxt_s;

    assign start_edge_s = start & ~start_q_r;
    assign accept_s     = (state_r == S_IDLE) & start_edge_s;
    assign cyc_last_s   = (cyc_cnt_r == CNT_W'(1));
    assign run_nxt_s    = (state_nxt_s == S_SETTLE) | (state_nxt_s == S_COUNT);

`ifdef PUF_MAJORITY_EN
    logic [1:0]              pass_r;
    logic [2:0][N_PAIRS-1:0] vote_r;

    function automatic logic [N_PAIRS-1:0] majority3(input logic [N_PAIRS-1:0] a,
                                                     input logic [N_PAIRS-1:0] b,
                                                     input logic [N_PAIRS-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign last_pass_s = (pass_r == 2'd2);
    assign resp_nxt_s  = majority3(vote_r[0], vote_r[1], cmp_bits);

    // Pass counter and vote buffer; a reset or a new run discards any partial vote.
    always_ff @(posedge clk) begin
        if (rst || accept_s) begin
            pass_r <= 2'd0;
            vote_r <= '{default: {N_PAIRS{1'b0}}};
        end else if (state_r == S_SAMPLE) begin
            case (pass_r)
                2'd0:    vote_r[0] <= cmp_bits;
                2'd1:    vote_r[1] <= cmp_bits;
                2'd2:    vote_r[2] <= cmp_bits;
                default: vote_r    <= vote_r;
            endcase
            pass_r <= last_pass_s ? pass_r : pass_r + 2'd1;
        end else begin
            pass_r <= pass_r;
            vote_r <= vote_r;
        end
    end
`else
    assign last_pass_s = 1'b1;
    assign resp_nxt_s  = cmp_bits;
`endif

    // State register and start-edge history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            start_q_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            start_q_r <= start;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE:   if (start_edge_s) state_nxt_s = S_CLEAR;  else state_nxt_s = S_IDLE;
            S_CLEAR:  state_nxt_s = S_SETTLE;
            S_SETTLE: if (cyc_last_s) state_nxt_s = S_COUNT;    else state_nxt_s = S_SETTLE;
            S_COUNT:  if (cyc_last_s) state_nxt_s = S_SAMPLE;   else state_nxt_s = S_COUNT;
            S_SAMPLE: if (last_pass_s) state_nxt_s = S_DONE;    else state_nxt_s = S_CLEAR;
            S_DONE:   if (ack) state_nxt_s = S_IDLE;            else state_nxt_s = S_DONE;
            default:  state_nxt_s = S_IDLE;
        endcase
    end

    // Shared settle/window down-counter; loaded on entry to SETTLE and COUNT, parks at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == S_CLEAR) begin
            cyc_cnt_r <= SETTLE_LD;
        end else if ((state_r == S_SETTLE) && cyc_last_s) begin
            cyc_cnt_r <= WINDOW_LD;
        end else if (cyc_cnt_r != {CNT_W{1'b0}}) begin
            cyc_cnt_r <= cyc_cnt_r - CNT_W'(1);
        end else begin
            cyc_cnt_r <= cyc_cnt_r;
        end
    end

    // Control outputs registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ro_en   <= {EN_W{1'b0}};
            cnt_clr <= 1'b0;
            cnt_en  <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            ro_en   <= run_nxt_s ? {EN_W{1'b1}} : {EN_W{1'b0}};
            cnt_clr <= (state_nxt_s == S_CLEAR);
            cnt_en  <= (state_nxt_s == S_COUNT);
            done    <= (state_nxt_s == S_DONE);
            busy    <= (state_nxt_s != S_IDLE);
        end
    end

    // Challenge latch and response capture at the final SAMPLE exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            challenge_out <= {CH_W{1'b0}};
            response      <= {N_PAIRS{1'b0}};
        end else begin
            if (accept_s) challenge_out <= challenge_in;
            else           challenge_out <= challenge_out;
            if ((state_r == S_SAMPLE) && last_pass_s) response <= resp_nxt_s;
            else                                      response <= response;
        end
    end
endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Self-checking bench for puf_eval_ctrl: table-driven runs plus reset/ack/start corner sequences,
// checked against a cycle-offset timeline model. Honours PUF_MAJORITY_EN.
module tb_puf_eval_ctrl;
    localparam int S = 4;
    localparam int W = 16;
    localparam int K = S + W + 2;
`ifdef PUF_MAJORITY_EN
    localparam int P = 3;
`else
    localparam int P = 1;
`endif
    localparam int L = P * K;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  challenge_in = 8'h00;
    logic        ack = 1'b0;
    logic [7:0]  cmp_bits = 8'h00;
    logic [7:0]  challenge_out;
    logic [31:0] ro_en;
    logic        cnt_clr, cnt_en, done, busy;
    logic [7:0]  response;

    int checks = 0;
    int failures = 0;

    puf_eval_ctrl #(.N_PAIRS(8), .CH_W(8), .EN_W(32), .SETTLE_CYCLES(S), .WINDOW_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .start(start), .challenge_in(challenge_in), .ack(ack),
        .cmp_bits(cmp_bits), .challenge_out(challenge_out), .ro_en(ro_en), .cnt_clr(cnt_clr),
        .cnt_en(cnt_en), .response(response), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ch;
        logic [7:0] c0, c1, c2;
        logic [7:0] exp_resp;
        int         hold;
        bit         noise;
        bit         keep_start;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack_ctl(input logic clr, input logic en, input logic bz,
                                             input logic dn, input logic [31:0] ro);
        return {28'd0, clr, en, bz, dn, ro};
    endfunction

    // Expected controls t edges after the accepted start edge.
    function automatic logic [63:0] exp_ctl(input int t);
        int   ph;
        logic ro;
        if (t >= L) return pack_ctl(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        ph = t % K;
        ro = (ph >= 1) && (ph <= S + W);
        return pack_ctl(ph == 0, (ph > S) && (ph <= S + W), 1'b1, 1'b0, {32{ro}});
    endfunction

    function automatic logic [7:0] model_resp(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] c);
        logic [7:0] r;
        int         n;
        if (P == 1) return a;
        for (int i = 0; i < 8; i++) begin
            n = int'(a[i]) + int'(b[i]) + int'(c[i]);
            r[i] = (n >= 2);
        end
        return r;
    endfunction

    task automatic run_eval(input vec_t v);
        int         first_done;
        int         en_cycles;
        int         pass;
        logic [7:0] pv;
        first_done = -1;
        en_cycles  = 0;
        start = 1'b0;
        ack   = 1'b0;
        @(negedge clk);
        challenge_in = v.ch;
        start = 1'b1;
        for (int t = 0; t <= L + v.hold; t++) begin
            @(negedge clk);
            chk("ctl", pack_ctl(cnt_clr, cnt_en, busy, done, ro_en), exp_ctl(t));
            chk("challenge_out", 64'(challenge_out), 64'(v.ch));
            if (t >= L) chk("response", 64'(response), 64'(v.exp_resp));
            if (done === 1'b1 && first_done < 0) first_done = t;
            if (cnt_en === 1'b1) en_cycles++;
            pass = (t < L) ? t / K : P - 1;
            pv   = (pass == 0) ? v.c0 : (pass == 1) ? v.c1 : v.c2;
            if ((t < L) && (t % K == K - 1)) cmp_bits = pv;
            else if (v.noise)                cmp_bits = 8'($urandom);
            else                             cmp_bits = pv;
            if (v.noise) begin
                challenge_in = 8'($urandom);
                if (t < L - 1) begin
                    ack   = 1'($urandom);
                    start = v.keep_start ? 1'b1 : 1'($urandom);
                end else begin
                    ack   = 1'b0;
                    start = v.keep_start;
                end
            end else begin
                start = v.keep_start;
            end
        end
        chk("done_latency", 64'(first_done), 64'(L));
        chk("cnt_en_cycles", 64'(en_cycles), 64'(P * W));
        ack = 1'b1;
        @(negedge clk);
        chk("ack_idle", pack_ctl(cnt_clr, cnt_en, busy, done, ro_en), 64'd0);
        ack = 1'b0;
        if (v.keep_start) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                chk("no_restart_busy", 64'(busy), 64'd0);
            end
            start = 1'b0;
        end
    endtask

    initial begin
        vec_t rv;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ctl", pack_ctl(cnt_clr, cnt_en, busy, done, ro_en), 64'd0);
        chk("reset_resp", 64'(response), 64'd0);
        chk("reset_chal", 64'(challenge_out), 64'd0);
        rst = 1'b0;
        @(negedge clk);

`ifdef PUF_MAJORITY_EN
        vecs[0] = '{ch: 8'hA5, c0: 8'hF0, c1: 8'hFF, c2: 8'h0F, exp_resp: 8'hFF, hold: 50, noise: 1'b0, keep_start: 1'b0};
        vecs[1] = '{ch: 8'hA5, c0: 8'h81, c1: 8'h18, c2: 8'h99, exp_resp: 8'h99, hold: 3,  noise: 1'b1, keep_start: 1'b0};
        vecs[2] = '{ch: 8'h3C, c0: 8'h00, c1: 8'h55, c2: 8'hAA, exp_resp: 8'h00, hold: 2,  noise: 1'b0, keep_start: 1'b1};
`else
        vecs[0] = '{ch: 8'hA5, c0: 8'h3C, c1: 8'h00, c2: 8'h00, exp_resp: 8'h3C, hold: 50, noise: 1'b0, keep_start: 1'b0};
        vecs[1] = '{ch: 8'hA5, c0: 8'h81, c1: 8'h00, c2: 8'h00, exp_resp: 8'h81, hold: 3,  noise: 1'b1, keep_start: 1'b0};
        vecs[2] = '{ch: 8'h3C, c0: 8'hC3, c1: 8'h00, c2: 8'h00, exp_resp: 8'hC3, hold: 2,  noise: 1'b0, keep_start: 1'b1};
`endif
        for (int i = 3; i < 7; i++) begin
            rv.ch = 8'($urandom);
            rv.c0 = 8'($urandom);
            rv.c1 = 8'($urandom);
            rv.c2 = 8'($urandom);
            rv.exp_resp   = model_resp(rv.c0, rv.c1, rv.c2);
            rv.hold       = $urandom_range(0, 5);
            rv.noise      = 1'b1;
            rv.keep_start = 1'b0;
            vecs[i] = rv;
        end

        for (int i = 0; i < 7; i++) run_eval(vecs[i]);

        // Reset in the middle of the last pass's counting window.
        start = 1'b0;
        @(negedge clk);
        challenge_in = 8'hC3;
        cmp_bits     = 8'h5A;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat ((P - 1) * K + S + 5) @(negedge clk);
        chk("pre_reset_count", 64'(cnt_en), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrun_reset_ctl", pack_ctl(cnt_clr, cnt_en, busy, done, ro_en), 64'd0);
        chk("midrun_reset_resp", 64'(response), 64'd0);
        chk("midrun_reset_chal", 64'(challenge_out), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        rv = '{ch: 8'h6E, c0: 8'h17, c1: 8'hE8, c2: 8'h17, exp_resp: model_resp(8'h17, 8'hE8, 8'h17),
               hold: 1, noise: 1'b0, keep_start: 1'b0};
        run_eval(rv);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
